// File: rtl/conv_pkg.sv
// Shared definitions for the convolver datapath stages.
//   psum_state_t : pass-control states of psum_accumulator
//   sat_to_line  : clamp an accumulator-width value to output line width
`ifndef WID_MAC_OUT
`define WID_MAC_OUT 24
`endif
`ifndef WID_LINE
`define WID_LINE 16
`endif

package conv_pkg;

  localparam int unsigned WidMacOut = `WID_MAC_OUT;
  localparam int unsigned WidLine   = `WID_LINE;
  localparam int unsigned WidAcc    = `WID_MAC_OUT + 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StDone
  } psum_state_t;

  // Value fits when every bit from the line sign bit upward equals the acc sign bit.
  function automatic logic signed [WidLine-1:0] sat_to_line(
    input logic signed [WidAcc-1:0] x
  );
    logic signed [WidLine-1:0] res;
    if (x[WidAcc-1:WidLine-1] == {(WidAcc - WidLine + 1){x[WidAcc-1]}}) begin
      res = x[WidLine-1:0];
    end else if (x[WidAcc-1]) begin
      res = {1'b1, {(WidLine - 1){1'b0}}};
    end else begin
      res = {1'b0, {(WidLine - 1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/out_fifo2.sv
// Two-entry in-order valid/ready FIFO with registered storage.
//   clk_i, rst_ni    : clock, async active-low reset (flushes contents)
//   push_i           : write push_data_i (caller guarantees not full)
//   out_valid_o/out_ready_i/out_data_o : output stream
//   count_o          : current occupancy (0..2)
module out_fifo2 #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    // Push and pop together leave the count unchanged.
    count_d  = count_q + {1'b0, push_i} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates per-pixel partial sums across channels for one output row.
// On the last channel adds bias, optional ReLU, saturates and streams out.
//   clk_i, rst_ni        : clock, async active-low reset (aborts a pass)
//   start_i              : begin a pass (sampled only when idle); latches config
//   num_pixels_i, num_channels_i, bias_i, relu_en_i : pass configuration
//   in_valid_i/in_ready_o/in_data_i    : MAC result stream, channel-major
//   out_valid_o/out_ready_i/out_data_o : saturated pixel results
//   busy_o : not idle;  done_o : one-cycle pass-complete pulse
module psum_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned WID_ACC = WidAcc
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [$clog2(DEPTH+1)-1:0]  num_pixels_i,
  input  logic [15:0]                 num_channels_i,
  input  logic signed [WidLine-1:0]   bias_i,
  input  logic                        relu_en_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic signed [WidMacOut-1:0] in_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic signed [WidLine-1:0]   out_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned PixW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  psum_state_t state_q, state_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [15:0]     ch_q, ch_d;

  logic [PixW-1:0]           npix_q;
  logic [15:0]               nch_q;
  logic signed [WidLine-1:0] bias_q;
  logic                      relu_q;

  logic signed [WID_ACC-1:0] psum_q [DEPTH];

  logic [1:0]                fifo_count;
  logic                      last_pix, last_ch, beat, push;
  logic [AddrW-1:0]          idx;
  logic signed [WID_ACC-1:0] in_ext, bias_ext, sum, res;
  logic signed [WidLine-1:0] push_data;

  assign idx      = pix_q[AddrW-1:0];
  assign last_pix = (pix_q == npix_q - PixW'(1));
  assign last_ch  = (ch_q == nch_q - 16'd1);

  // No path from out_ready: the last channel only stalls on FIFO occupancy.
  assign in_ready_o = (state_q == StAccum) && (!last_ch || (fifo_count < 2'd2));
  assign beat       = in_valid_i && in_ready_o;
  assign push       = beat && last_ch;

  assign in_ext   = {{(WID_ACC - WidMacOut){in_data_i[WidMacOut-1]}}, in_data_i};
  assign bias_ext = {{(WID_ACC - WidLine){bias_q[WidLine-1]}}, bias_q};

  always_comb begin
    // Channel 0 ignores stale array contents, so the array needs no reset.
    sum = ((ch_q == '0) ? '0 : psum_q[idx]) + in_ext;
    res = sum + bias_ext;
    if (relu_q && res[WID_ACC-1]) begin
      res = '0;
    end
    push_data = sat_to_line(WidAcc'(res));
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pix_d   = '0;
          ch_d    = '0;
          state_d = ((num_pixels_i == '0) || (num_channels_i == '0)) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (beat) begin
          if (last_pix) begin
            pix_d = '0;
            if (last_ch) begin
              state_d = StDrain;
            end else begin
              ch_d = ch_q + 16'd1;
            end
          end else begin
            pix_d = pix_q + PixW'(1);
          end
        end
      end
      StDrain: begin
        if (fifo_count == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pix_q   <= '0;
      ch_q    <= '0;
      npix_q  <= '0;
      nch_q   <= '0;
      bias_q  <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
      if ((state_q == StIdle) && start_i) begin
        npix_q <= num_pixels_i;
        nch_q  <= num_channels_i;
        bias_q <= bias_i;
        relu_q <= relu_en_i;
      end
    end
  end

  // Last-channel beats go to the FIFO only; the array keeps channels 0..N-2.
  always_ff @(posedge clk_i) begin
    if (beat && !last_ch) begin
      psum_q[idx] <= sum;
    end
  end

  out_fifo2 #(
    .Width(WidLine)
  ) u_out_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_data),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (fifo_count)
  );

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator with a behavioural row model.
`ifndef WID_MAC_OUT
`define WID_MAC_OUT 24
`endif
`ifndef WID_LINE
`define WID_LINE 16
`endif

module tb_psum_accumulator;
  import conv_pkg::*;

  localparam int unsigned Depth = 256;
  localparam int unsigned PixW  = $clog2(Depth + 1);

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b1;
  logic                        start = 1'b0;
  logic [PixW-1:0]             num_pixels = '0;
  logic [15:0]                 num_channels = '0;
  logic signed [WidLine-1:0]   bias = '0;
  logic                        relu_en = 1'b0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic signed [WidMacOut-1:0] in_data = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic signed [WidLine-1:0]   out_data;
  logic                        busy;
  logic                        done;

  psum_accumulator #(
    .DEPTH(Depth)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .num_pixels_i   (num_pixels),
    .num_channels_i (num_channels),
    .bias_i         (bias),
    .relu_en_i      (relu_en),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stim[$];
  int exp_q[$];
  int mdl[$];
  int got_q[$];
  int lit_q[$];
  bit rand_ready = 1'b0;
  int max_gap = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Row model: sum each pixel over channels, add bias, ReLU, clamp to line width.
  task automatic model_pass(input int np, input int nc, input int b, input bit relu);
    longint lmax = (longint'(1) <<< (WidLine - 1)) - 1;
    longint lmin = -lmax - 1;
    mdl.delete();
    for (int p = 0; p < np; p++) begin
      longint acc = b;
      for (int c = 0; c < nc; c++) acc += stim[c * np + p];
      if (relu && acc < 0) acc = 0;
      if (acc > lmax) acc = lmax;
      if (acc < lmin) acc = lmin;
      mdl.push_back(int'(acc));
      exp_q.push_back(int'(acc));
    end
  endtask

  // Compare process: every handshaken output against the model queue.
  bit prev_stall = 1'b0;
  int prev_data  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("out_valid_hold", out_valid, 1);
        check_eq("out_data_hold", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_data));
        check_eq("model_has_entry", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("out_data", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(out_data);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

  // All driving tasks begin and end 1 time unit after a rising edge.
  task automatic do_start(input int np, input int nc, input int b, input bit relu);
    num_pixels   = PixW'(np);
    num_channels = 16'(nc);
    bias         = WidLine'(b);
    relu_en      = relu;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input int d);
    int  n = 0;
    bit  acc;
    in_valid = 1'b1;
    in_data  = WidMacOut'(d);
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 500) begin
        check_eq("beat_accepted", in_ready, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 2000) begin
        check_eq("done_seen", done, 1);
        break;
      end
    end
  endtask

  task automatic run_pass(input int np, input int nc, input int b, input bit relu,
                          input bit lat_chk, input bit mid_start);
    int waited;
    got_q.delete();
    model_pass(np, nc, b, relu);
    do_start(np, nc, b, relu);
    check_eq("busy_after_start", busy, 1);
    for (int i = 0; i < np * nc; i++) begin
      if (nc > 1 && i == np * (nc - 1)) begin
        check_eq("no_out_before_last_ch", got_q.size(), 0);
        check_eq("no_valid_before_last_ch", out_valid, 0);
      end
      if (mid_start && i == 1) begin
        num_pixels   = PixW'(1);
        num_channels = 16'd0;
        bias         = WidLine'(123);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("start_ignored_busy", busy, 1);
      end
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      drive_beat(stim[i]);
      if (lat_chk) begin
        check_eq("lat_valid", out_valid, 1);
        check_eq("lat_data", out_data, mdl[i]);
      end
    end
    wait_done(waited);
    if (lat_chk) check_eq("done_delay", waited, 2);
    check_eq("model_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check_eq("busy_after_done", busy, 0);
    check_eq("done_is_pulse", done, 0);
  endtask

  task automatic check_got();
    check_eq("got_count", got_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < got_q.size(); i++) begin
      check_eq("got_value", got_q[i], lit_q[i]);
    end
  endtask

  initial begin
    int idx;
    bit acc;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single channel with latency and done timing.
    stim = '{1, -2, 3, -40};
    run_pass(4, 1, 10, 1'b0, 1'b1, 1'b0);
    lit_q = '{11, 8, 13, -30};
    check_got();

    // Three channels.
    stim = '{5, 7, 5, 7, 5, 7};
    run_pass(2, 3, 0, 1'b0, 1'b0, 1'b0);
    lit_q = '{15, 21};
    check_got();

    // ReLU and saturation.
    stim = '{-5, 40000, -70000};
    run_pass(3, 1, 0, 1'b1, 1'b0, 1'b0);
    lit_q = '{0, 32767, 0};
    check_got();
    run_pass(3, 1, 0, 1'b0, 1'b0, 1'b0);
    lit_q = '{-5, 32767, -32768};
    check_got();

    // Backpressure: only two results fit while the output is stalled.
    stim = '{100, 101, 102, 103, 104, 105};
    got_q.delete();
    model_pass(6, 1, 0, 1'b0);
    out_ready = 1'b0;
    do_start(6, 1, 0, 1'b0);
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = WidMacOut'(stim[idx]);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", idx, 2);
    check_eq("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) drive_beat(stim[i]);
    wait_done(idx);
    check_eq("bp_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    lit_q = '{100, 101, 102, 103, 104, 105};
    check_got();

    // Degenerate configurations.
    do_start(3, 0, 5, 1'b0);
    check_eq("zero_ch_done", done, 1);
    check_eq("zero_ch_no_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("zero_ch_idle", busy, 0);
    do_start(0, 2, 5, 1'b0);
    check_eq("zero_pix_done", done, 1);
    check_eq("zero_pix_no_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Start while busy is ignored.
    stim = '{1, 2, 3, 4, 5, 6};
    run_pass(3, 2, -1, 1'b0, 1'b0, 1'b1);
    lit_q = '{4, 6, 8};
    check_got();

    // Reset with one result pending, then a fresh pass.
    stim = '{77, 88};
    got_q.delete();
    model_pass(2, 1, 0, 1'b0);
    out_ready = 1'b0;
    do_start(2, 1, 0, 1'b0);
    drive_beat(stim[0]);
    check_eq("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stim = '{3, 4, 10, 20};
    run_pass(2, 2, 1, 1'b0, 1'b0, 1'b0);
    lit_q = '{14, 25};
    check_got();

    // Randomized passes with gaps and random backpressure.
    rand_ready = 1'b1;
    max_gap    = 2;
    for (int k = 0; k < 12; k++) begin
      int np = (k == 11) ? int'(Depth) : int'($urandom_range(1, 8));
      int nc = (k == 11) ? 2 : int'($urandom_range(1, 4));
      int b  = int'($urandom_range(0, 65535)) - 32768;
      bit r  = 1'($urandom_range(0, 1));
      stim.delete();
      for (int i = 0; i < np * nc; i++) begin
        if ($urandom_range(0, 2) == 0) stim.push_back(int'($urandom_range(0, 16777215)) - 8388608);
        else stim.push_back(int'($urandom_range(0, 100000)) - 50000);
      end
      run_pass(np, nc, b, r, 1'b0, 1'b0);
      check_eq("rand_out_count", got_q.size(), np);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
